lifo_stack: RTL
===============

LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of storage entries (power of two, at least 2).
REQ-003 Parameter PTR_W, default 3, width of the stack pointer; SHALL satisfy 2^PTR_W == DEPTH.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 push  input  1  write request; din is written on the top of the stack.
REQ-007 pop  input  1  read request; the top entry is removed and presented on dout.
REQ-008 din  input  WIDTH  write data.
REQ-009 dout  output  WIDTH  registered pop data.
REQ-010 dout_valid  output  1  one-cycle pulse: dout was loaded by an accepted pop.
REQ-011 count  output  PTR_W+1  number of entries held, 0..DEPTH.
REQ-012 full  output  1  high when count == DEPTH.
REQ-013 empty  output  1  high when count == 0.
REQ-014 overflow  output  1  sticky error flag for a push refused while full (see Configuration).
REQ-015 underflow  output  1  sticky error flag for a pop refused while empty (see Configuration).

Function
REQ-016 The block SHALL keep a stack pointer sp equal to count, and a DEPTH x WIDTH array; entry sp-1 is the top.
REQ-017 push only, not full: mem[sp] <= din, sp <= sp+1; dout and dout_valid are unchanged/low.
REQ-018 pop only, not empty: dout <= mem[sp-1], sp <= sp-1, dout_valid = 1 in the following cycle (latency 1).
REQ-019 push and pop in the same cycle, not empty (including full): dout <= mem[sp-1], mem[sp-1] <= din, sp unchanged, dout_valid = 1 (replace-top).
REQ-020 push and pop in the same cycle while empty: the pop is refused and the push completes (sp 0->1); dout_valid stays 0.
REQ-021 push while full without pop: refused; memory and sp unchanged.
REQ-022 pop while empty: refused; dout holds its last value and dout_valid = 0.
REQ-023 dout SHALL hold its value between accepted pops; dout_valid SHALL never be high for two cycles unless pops are accepted on consecutive cycles.
REQ-024 full, empty and count SHALL be registered, or decoded from the registered sp only, and SHALL reflect the post-edge sp in the same cycle.
REQ-025 sp SHALL never exceed DEPTH or go below 0; the pointer never wraps.

Reset
REQ-026 On reset high: sp = 0, count = 0, empty = 1, full = 0, dout = 0, dout_valid = 0, overflow = 0, underflow = 0, taking effect immediately, without waiting for a clock edge.
REQ-027 Memory contents SHALL NOT be reset; they are unreachable until written again.
REQ-028 Reset asserted mid-operation SHALL discard any push or pop in progress in that cycle; the first operation is accepted on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro LIFO_ERR_FLAG_EN defined: overflow SHALL be set by a refused push (REQ-021) and underflow by a refused pop (REQ-020, REQ-022); both stay set until reset.
REQ-030 Macro LIFO_ERR_FLAG_EN undefined: the overflow and underflow ports SHALL remain present and SHALL be driven constant 0, and no flag logic SHALL be built.

Verification (WIDTH=8, DEPTH=4)
REQ-031 Reset, then push 0x11, 0x22, 0x33, 0x44 -> count = 4, full = 1; four pops -> dout = 0x44, 0x33, 0x22, 0x11 with dout_valid high in each following cycle; then empty = 1.
REQ-032 Full, then push 0x55 -> refused, count stays 4; the next pop gives 0x44; with LIFO_ERR_FLAG_EN, overflow = 1 until reset.
REQ-033 Empty, then pop -> dout holds its previous value, dout_valid = 0; with LIFO_ERR_FLAG_EN, underflow = 1; without the macro, underflow stays 0.
REQ-034 Stack holding 0x11, 0x22, then push 0x99 with pop in the same cycle -> dout = 0x22, count stays 2; the next pop gives 0x99.
REQ-035 Empty, then push 0x7A with pop in the same cycle -> count = 1, dout_valid = 0; the next pop gives 0x7A.
REQ-036 Assert reset between clock edges while count = 3 -> count = 0, empty = 1, dout = 0, both flags 0 before the next edge.

Source files
------------

// File: rtl/lifo_stack.sv
// ---------------------------------------------------------------------------
// lifo_stack -- single-clock LIFO (stack) with registered pop data.
//
// Optional build macro: LIFO_ERR_FLAG_EN
//   defined   : overflow/underflow are sticky error flags, cleared only by reset
//   undefined : overflow/underflow ports exist but are tied to 0
//
// Parameters
//   WIDTH  data word width
//   DEPTH  number of entries (power of two, >= 2)
//   PTR_W  log2(DEPTH); the stack pointer is PTR_W+1 bits so it can hold DEPTH
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   push, din   write request / data, written on top of the stack
//   pop         read request, top entry removed and presented on dout
//   dout        registered pop data, held between accepted pops
//   dout_valid  one-cycle pulse after each accepted pop
//   count       number of entries held (0..DEPTH)
//   full/empty  decoded from the registered stack pointer
//   overflow    sticky: push refused while full
//   underflow   sticky: pop refused while empty
// ---------------------------------------------------------------------------
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ZERO_C  = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   sp_r;
    logic [PTR_W:0]   sp_nxt_s;
    logic [PTR_W-1:0] top_idx_s;
    logic [PTR_W-1:0] wr_idx_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_acc_s;
    logic             push_acc_s;
    logic [WIDTH-1:0] dout_r;
    logic             dout_valid_r;

    assign full_s  = (sp_r == DEPTH_C);
    assign empty_s = (sp_r == ZERO_C);
    // Low pointer bits minus one wrap to DEPTH-1 when sp == DEPTH, which is
    // exactly the top entry of a full stack.
    assign top_idx_s = sp_r[PTR_W-1:0] - PTR_W'(1'b1);

    // Accept/refuse decisions, write address and next stack pointer.
    always_comb begin
        pop_acc_s  = 1'b0;
        push_acc_s = 1'b0;
        wr_idx_s   = sp_r[PTR_W-1:0];
        sp_nxt_s   = sp_r;
        if (pop && !empty_s) begin
            pop_acc_s = 1'b1;
        end else begin
            pop_acc_s = 1'b0;
        end
        // A push while full is still accepted when paired with an accepted pop
        // (replace-top); a push paired with a refused pop behaves as push only.
        if (push && (pop_acc_s || !full_s)) begin
            push_acc_s = 1'b1;
        end else begin
            push_acc_s = 1'b0;
        end
        if (pop_acc_s) begin
            wr_idx_s = top_idx_s;
        end else begin
            wr_idx_s = sp_r[PTR_W-1:0];
        end
        if (push_acc_s && !pop_acc_s) begin
            sp_nxt_s = sp_r + ONE_C;
        end else if (pop_acc_s && !push_acc_s) begin
            sp_nxt_s = sp_r - ONE_C;
        end else begin
            sp_nxt_s = sp_r;
        end
    end

    // Stack pointer and registered pop data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_r         <= ZERO_C;
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
        end else begin
            sp_r         <= sp_nxt_s;
            dout_valid_r <= pop_acc_s;
            if (pop_acc_s) begin
                dout_r <= mem_r[top_idx_s];
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    // Storage array: not reset; writes are suppressed while reset is high so a
    // push in flight during reset is discarded.
    always_ff @(posedge clk) begin
        if (push_acc_s && !reset) begin
            mem_r[wr_idx_s] <= din;
        end
    end

`ifdef LIFO_ERR_FLAG_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push && !pop && full_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (pop && empty_s) begin
                underflow_r <= 1'b1;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign count      = sp_r;
    assign full       = full_s;
    assign empty      = empty_s;

endmodule
